// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode constants, instruction field
// bit positions and the fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  // Opcode constants
  localparam logic [5:0] R_TYPE  = 6'b000000;
  localparam logic [5:0] HALT_OP = 6'b111111;

  // Instruction field bit positions
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  // Fetch FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DROP  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } fetchState_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slice of a 32-bit instruction word into its decode fields.
// Shared between the fetch unit and the decode stage.
module instr_field_split
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [5:0]         Op,
  output logic [4:0]         Rs,
  output logic [4:0]         Rt,
  output logic [4:0]         Rd,
  output logic [5:0]         Funct,
  output logic [15:0]        Imm
);

  assign Op    = instr[OP_MSB:OP_LSB];
  assign Rs    = instr[RS_MSB:RS_LSB];
  assign Rt    = instr[RT_MSB:RT_LSB];
  assign Rd    = instr[RD_MSB:RD_LSB];
  assign Funct = instr[FUNCT_MSB:FUNCT_LSB];
  assign Imm   = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the req/ack handshake to
// instruction memory and the valid/ready handshake to decode, and handles
// redirects (with flush of the in-flight fetch) and the halt opcode.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]        HALT_OP  = cpu_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [5:0]        Op,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [5:0]        Funct,
  output logic [15:0]       Imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetchState_e        state;
  logic [ADDR_W-1:0]  pcReg;
  logic [ADDR_W-1:0]  memAddrReg;
  logic [ADDR_W-1:0]  pcOutReg;
  logic [INSTR_W-1:0] irReg;
  logic               memReqReg;
  logic               instrValidReg;
  logic               haltedReg;

  logic [ADDR_W-1:0]  redirTarget;
  logic [ADDR_W-1:0]  pcPlus4;
  logic               handshake;

  // Targets are always word aligned; masking keeps every input bit in use.
  assign redirTarget = redirect_pc & ~ADDR_W'(3);
  // Wraps modulo 2^ADDR_W by construction.
  assign pcPlus4     = pcReg + ADDR_W'(4);
  assign handshake   = instrValidReg && instr_ready;

  assign mem_req     = memReqReg;
  assign mem_addr    = memAddrReg;
  assign instr_valid = instrValidReg;
  assign pc_out      = pcOutReg;
  assign halted      = haltedReg;

  // Decode fields are always taken from IR, never straight from memory.
  instr_field_split uFieldSplit (
    .instr (irReg),
    .Op    (Op),
    .Rs    (Rs),
    .Rt    (Rt),
    .Rd    (Rd),
    .Funct (Funct),
    .Imm   (Imm)
  );

  // Fetch FSM with PC, IR and all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pcReg         <= RESET_PC;
      memAddrReg    <= RESET_PC;
      pcOutReg      <= RESET_PC;
      irReg         <= '0;
      memReqReg     <= 1'b0;
      instrValidReg <= 1'b0;
      haltedReg     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Redirect has priority over start and keeps the unit idle.
          if (redirect) begin
            pcReg      <= redirTarget;
            memAddrReg <= redirTarget;
          end else if (start) begin
            state      <= ST_REQ;
            memReqReg  <= 1'b1;
            memAddrReg <= pcReg;
          end
        end

        ST_REQ: begin
          if (redirect) begin
            pcReg <= redirTarget;
            if (mem_ack) begin
              // Returning data belongs to the old path: drop it, refetch now.
              memAddrReg <= redirTarget;
            end else begin
              // Request stays up on the old address until memory answers.
              state <= ST_DROP;
            end
          end else if (mem_ack) begin
            irReg         <= mem_rdata;
            pcOutReg      <= pcReg;
            memReqReg     <= 1'b0;
            instrValidReg <= 1'b1;
            state         <= ST_ISSUE;
          end
        end

        ST_DROP: begin
          if (mem_ack) begin
            state      <= ST_REQ;
            memAddrReg <= redirect ? redirTarget : pcReg;
            if (redirect) begin
              pcReg <= redirTarget;
            end
          end else if (redirect) begin
            pcReg <= redirTarget;
          end
        end

        ST_ISSUE: begin
          if (handshake && (Op == HALT_OP)) begin
            // A consumed halt beats any coincident redirect.
            instrValidReg <= 1'b0;
            haltedReg     <= 1'b1;
            state         <= ST_HALT;
          end else if (redirect) begin
            // Flush or consume; either way the target beats PC+4.
            pcReg         <= redirTarget;
            memAddrReg    <= redirTarget;
            memReqReg     <= 1'b1;
            instrValidReg <= 1'b0;
            state         <= ST_REQ;
          end else if (handshake) begin
            pcReg         <= pcPlus4;
            memAddrReg    <= pcPlus4;
            memReqReg     <= 1'b1;
            instrValidReg <= 1'b0;
            state         <= ST_REQ;
          end
        end

        ST_HALT: begin
          memReqReg     <= 1'b0;
          instrValidReg <= 1'b0;
          haltedReg     <= 1'b1;
        end

        default: begin
          state         <= ST_IDLE;
          memReqReg     <= 1'b0;
          instrValidReg <= 1'b0;
          haltedReg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end that feeds the control-unit decoder: fetches 32-bit instruction words from instruction memory and presents Op plus the register and immediate fields downstream.
- Holds the PC and runs a request/acknowledge handshake to memory and a valid/ready handshake to the decode stage.
- Supports a branch/jump redirect that flushes the in-flight fetch, and a halt opcode.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC value after reset.
- HALT_OP, 6'b111111, opcode that stops fetching once issued.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins fetching from the current PC when in IDLE.
- mem_req  out  1  fetch request; held high until mem_ack.
- mem_addr  out  ADDR_W  word-aligned fetch address (low 2 bits always 0).
- mem_ack  in  1  one-cycle pulse; mem_rdata valid this cycle.
- mem_rdata  in  32  instruction word.
- Op  out  6  instr[31:26].
- Rs  out  5  instr[25:21].
- Rt  out  5  instr[20:16].
- Rd  out  5  instr[15:11].
- Funct  out  6  instr[5:0].
- Imm  out  16  instr[15:0].
- instr_valid  out  1  fields valid for the decode stage.
- instr_ready  in  1  decode stage accepts when valid and ready are both high.
- pc_out  out  ADDR_W  address of the instruction currently held in IR.
- redirect  in  1  one-cycle pulse; load new PC and flush.
- redirect_pc  in  ADDR_W  target; bits [1:0] forced to 0.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async on rst_n low):
  - PC=RESET_PC, IR=0, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, halted=0, pc_out=RESET_PC, all field outputs 0.
- States: IDLE, REQ, DROP, ISSUE, HALT.
- IDLE:
  - start -> REQ.
  - redirect in IDLE loads PC and stays in IDLE.
- REQ:
  - mem_req=1, mem_addr=PC, both stable until mem_ack.
  - On mem_ack: IR<=mem_rdata, pc_out<=PC, go to ISSUE. instr_valid rises the cycle after the ack.
  - Minimum fetch-to-valid latency is 2 cycles (req asserted, ack, valid).
- ISSUE:
  - instr_valid=1; fields and pc_out are stable while valid && !ready.
  - On handshake: if Op==HALT_OP go to HALT, otherwise PC<=PC+4 and go to REQ. mem_req is reasserted the next cycle.
- HALT: instr_valid=0, mem_req=0, halted=1. Only reset leaves HALT; start and redirect are ignored.
- Redirect in REQ:
  - PC<=redirect_pc and go to DROP. mem_req stays high with the old address until the ack.
  - The next mem_ack is discarded, then go to REQ with the new PC.
  - If redirect and mem_ack occur in the same cycle: data is discarded, PC<=target, go directly to REQ.
- Redirect in DROP: PC<=redirect_pc (last redirect wins), stay in DROP.
  - If mem_ack occurs in the same cycle: discard the data, PC<=target, go to REQ.
- Redirect in ISSUE without handshake: the instruction is flushed. instr_valid=0 next cycle, PC<=target, go to REQ.
- Redirect in ISSUE with handshake in the same cycle:
  - The instruction counts as consumed.
  - PC<=target (redirect wins over +4), go to REQ.
  - If the consumed Op==HALT_OP, HALT wins and the redirect is dropped.
- PC arithmetic is modulo 2^ADDR_W. PC+4 wraps from 32'hFFFF_FFFC to 0 with no flag.
- start is ignored in every state except IDLE.
- instr_valid never rises in the same cycle as mem_ack. Fields are driven from IR only.

Decomposition:
- Shared package (cpu_pkg): opcode constants (R_TYPE=6'b000000, HALT_OP), instruction field bit positions, fetch FSM state enum.
- One natural sub-module, instr_field_split: a combinational slice of IR into Op/Rs/Rt/Rd/Funct/Imm, reusable by the decode stage.
- FSM and PC logic stay in the top module.

Test Plan:
- Reset and start: rst_n low mid-fetch, release, start.
  - mem_req=1, mem_addr=0.
  - ack with 32'h0000_0820 -> instr_valid next cycle, Op=0, Rs=0, Rt=0, Rd=1, Funct=6'h20, pc_out=0.
- Stall:
  - Hold instr_ready=0 for 5 cycles: fields and pc_out stay constant and no mem_req is issued.
  - Raise ready: next fetch has mem_addr=4.
- Variable memory latency: ack after 1, 3, and 7 cycles. mem_addr is stable throughout and instructions are issued in order at PC 0, 4, 8.
- Redirect during REQ:
  - Redirect to 32'h0000_0103 while waiting; the old ack is discarded (no instr_valid).
  - Next mem_addr=32'h0000_0100.
  - Repeat with redirect and ack in the same cycle: same result.
- Redirect during ISSUE:
  - Without ready: the instruction is flushed and the next mem_addr is the target.
  - With ready in the same cycle: one handshake is counted and the next mem_addr is the target, not PC+4.
- Halt and wrap:
  - Issue 32'hFC00_0000: after the handshake, halted=1 and mem_req stays 0 for 20 cycles despite start and redirect.
  - Separately, redirect to 32'hFFFF_FFFC and issue: next mem_addr=0.
